// File: rtl/stage_skid_reg_pkg.sv
// Shared definitions for the stage_skid_reg pipeline stage:
// FSM state encoding and default payload/counter widths.
package stage_skid_reg_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_CTRL_W = 8;
    localparam int unsigned DEF_CNT_W  = 16;

    // EMPTY: nothing held; FULL: main only; SKID: main and skid both held
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b10
    } state_t;

endpackage

// File: rtl/stage_skid_reg_payload.sv
// stage_payload_reg: one control+data payload register with load,
// synchronous clear (priority over load) and asynchronous active-low reset.
module stage_payload_reg #(
    parameter int unsigned W = 40
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         CLR,
    input  logic         Load,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q
);

    // Payload storage: reset/clear zero the entry, otherwise load on request
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Q <= '0;
        end else if (CLR) begin
            Q <= '0;
        end else if (Load) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/stage_skid_reg.sv
// stage_skid_reg: two-entry skid-buffered pipeline stage (D -> E).
// A main register drives the E outputs; a skid register absorbs the one
// entry accepted while ReadyD (registered) was still high under backpressure.
// Optional feature: define STAGE_BUBBLE_CNT_EN to add the saturating
// BubbleCnt output (cycles with ReadyE=1 and ValidE=0).
module stage_skid_reg
    import stage_skid_reg_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CTRL_W = DEF_CTRL_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CLR,
    input  logic              ValidD,
    output logic              ReadyD,
    input  logic [CTRL_W-1:0] CtrlD,
    input  logic [DATA_W-1:0] DataD,
    output logic              ValidE,
    input  logic              ReadyE,
    output logic [CTRL_W-1:0] CtrlE,
    output logic [DATA_W-1:0] DataE
`ifdef STAGE_BUBBLE_CNT_EN
    ,
    output logic [CNT_W-1:0]  BubbleCnt
`endif
);

    localparam int unsigned PW = CTRL_W + DATA_W;

    state_t          state, state_nxt;
    logic            ready_q;
    logic            xfer_in, xfer_out;
    logic            main_load, skid_load;
    logic [PW-1:0]   main_d, main_q, skid_q;

    assign ValidE   = (state != EMPTY);
    assign ReadyD   = ready_q;
    assign xfer_in  = ValidD && ready_q;
    assign xfer_out = ValidE && ReadyE;
    assign {CtrlE, DataE} = main_q;

    // Next-state and register-load decode; CLR overrides every other input
    always_comb begin
        state_nxt = state;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = {CtrlD, DataD};
        if (CLR) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (xfer_in) begin
                        main_load = 1'b1;
                        state_nxt = FULL;
                    end
                end
                FULL: begin
                    if (xfer_in && xfer_out) begin
                        main_load = 1'b1;
                    end else if (xfer_out) begin
                        state_nxt = EMPTY;
                    end else if (xfer_in) begin
                        skid_load = 1'b1;
                        state_nxt = SKID;
                    end
                end
                SKID: begin
                    main_d = skid_q;
                    if (xfer_out) begin
                        main_load = 1'b1;
                        state_nxt = FULL;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered ready: low only when both entries will be occupied
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= (state_nxt != SKID);
        end
    end

    stage_payload_reg #(.W(PW)) u_main (
        .CLK  (CLK),
        .RST  (RST),
        .CLR  (CLR),
        .Load (main_load),
        .D    (main_d),
        .Q    (main_q)
    );

    stage_payload_reg #(.W(PW)) u_skid (
        .CLK  (CLK),
        .RST  (RST),
        .CLR  (CLR),
        .Load (skid_load),
        .D    ({CtrlD, DataD}),
        .Q    (skid_q)
    );

`ifdef STAGE_BUBBLE_CNT_EN
    // Saturating count of idle cycles seen by a ready consumer; ignores CLR
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            BubbleCnt <= '0;
        end else if (ReadyE && !ValidE && (BubbleCnt != '1)) begin
            BubbleCnt <= BubbleCnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_stage_skid_reg.sv
// Self-checking bench for stage_skid_reg. A queue-based model (capacity 2,
// registered ready) predicts ValidE/ReadyD/payload every cycle.
// Build with STAGE_BUBBLE_CNT_EN defined to also exercise BubbleCnt (CNT_W=4).
module tb_stage_skid_reg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 8;
`ifdef STAGE_BUBBLE_CNT_EN
    localparam int unsigned CNT_W = 4;
`else
    localparam int unsigned CNT_W = 16;
`endif
    localparam int unsigned BMAX = (1 << CNT_W) - 1;

    logic              CLK = 1'b0;
    logic              RST;
    logic              CLR;
    logic              ValidD;
    logic              ReadyD;
    logic [CTRL_W-1:0] CtrlD;
    logic [DATA_W-1:0] DataD;
    logic              ValidE;
    logic              ReadyE;
    logic [CTRL_W-1:0] CtrlE;
    logic [DATA_W-1:0] DataE;
`ifdef STAGE_BUBBLE_CNT_EN
    logic [CNT_W-1:0]  BubbleCnt;
`endif

    stage_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .CLR    (CLR),
        .ValidD (ValidD),
        .ReadyD (ReadyD),
        .CtrlD  (CtrlD),
        .DataD  (DataD),
        .ValidE (ValidE),
        .ReadyE (ReadyE),
        .CtrlE  (CtrlE),
        .DataE  (DataE)
`ifdef STAGE_BUBBLE_CNT_EN
        ,
        .BubbleCnt (BubbleCnt)
`endif
    );

    always #5 CLK = ~CLK;

    int unsigned tests = 0;
    int unsigned fails = 0;

    // reference model state
    logic [39:0] q[$];
    logic [39:0] out_log[$];
    bit          rdy_m;
    bit          zero_m;
    int unsigned bub_m;
    int unsigned outs;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        rdy_m  = 1'b0;
        zero_m = 1'b1;
        bub_m  = 0;
    endtask

    task automatic check_outputs();
        chk("ValidE", {63'd0, ValidE}, {63'd0, q.size() != 0});
        chk("ReadyD", {63'd0, ReadyD}, {63'd0, rdy_m});
        if (q.size() != 0)
            chk("payload", {24'd0, CtrlE, DataE}, {24'd0, q[0]});
        else if (zero_m)
            chk("payload_zero", {24'd0, CtrlE, DataE}, 64'd0);
`ifdef STAGE_BUBBLE_CNT_EN
        chk("BubbleCnt", {60'd0, BubbleCnt}, 64'(bub_m));
`endif
    endtask

    // Drive one cycle's inputs at the falling edge, advance the model, check after the next edge
    task automatic cycle(input logic vd, input logic [7:0] c, input logic [31:0] d,
                         input logic re, input logic clr);
        bit in_x, out_x;
        ValidD = vd; CtrlD = c; DataD = d; ReadyE = re; CLR = clr;
        in_x  = vd && rdy_m;
        out_x = re && (q.size() != 0);
        if (re && (q.size() == 0) && (bub_m < BMAX)) bub_m++;
        if (clr) begin
            q.delete();
            zero_m = 1'b1;
        end else begin
            if (out_x) begin
                out_log.push_back(q.pop_front());
                outs++;
            end
            if (in_x) begin
                q.push_back({c, d});
                zero_m = 1'b0;
            end
        end
        rdy_m = (q.size() < 2);
        @(posedge CLK);
        @(negedge CLK);
        check_outputs();
    endtask

    initial begin
        int unsigned base;
        RST = 1'b0; CLR = 1'b0; ValidD = 1'b0; ReadyE = 1'b0; CtrlD = '0; DataD = '0;
        model_reset();
        outs = 0;

        // reset values
        #2;
        chk("rst_ValidE", {63'd0, ValidE}, 64'd0);
        chk("rst_ReadyD", {63'd0, ReadyD}, 64'd0);
        chk("rst_payload", {24'd0, CtrlE, DataE}, 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("ReadyD_before_edge", {63'd0, ReadyD}, 64'd0);
        cycle(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
        chk("ReadyD_after_edge", {63'd0, ReadyD}, 64'd1);

        // single entry, one-cycle latency
        cycle(1'b1, 8'hA5, 32'h1234_5678, 1'b1, 1'b0);
        chk("single_ValidE", {63'd0, ValidE}, 64'd1);
        chk("single_CtrlE", {56'd0, CtrlE}, 64'hA5);
        chk("single_DataE", {32'd0, DataE}, 64'h1234_5678);
        cycle(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);

        // backpressure: 1,2 accepted, 3 refused until space frees
        out_log.delete();
        cycle(1'b1, 8'h01, 32'h1, 1'b0, 1'b0);
        cycle(1'b1, 8'h02, 32'h2, 1'b0, 1'b0);
        chk("bp_ReadyD_low", {63'd0, ReadyD}, 64'd0);
        cycle(1'b1, 8'h03, 32'h3, 1'b0, 1'b0);
        chk("bp_held_CtrlE", {56'd0, CtrlE}, 64'h01);
        cycle(1'b1, 8'h03, 32'h3, 1'b1, 1'b0);
        cycle(1'b1, 8'h03, 32'h3, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
        chk("bp_out_count", 64'(out_log.size()), 64'd3);
        for (int i = 0; i < 3 && i < out_log.size(); i++)
            chk("bp_order", {24'd0, out_log[i]}, {24'd0, 8'(i + 1), 32'(i + 1)});

        // streaming: 100 entries, one per cycle
        base = outs;
        for (int i = 0; i < 100; i++)
            cycle(1'b1, 8'($urandom), $urandom, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
        chk("stream_count", 64'(outs - base), 64'd100);

        // randomized traffic with occasional flush
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), 8'($urandom), $urandom,
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0));

        // flush while in SKID, with an entry offered
        cycle(1'b0, 8'h00, 32'h0, 1'b1, 1'b1);
        cycle(1'b1, 8'h11, 32'h1111_1111, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 32'h2222_2222, 1'b0, 1'b0);
        chk("skid_ReadyD", {63'd0, ReadyD}, 64'd0);
        cycle(1'b1, 8'h77, 32'hDEAD_BEEF, 1'b0, 1'b1);
        chk("flush_ValidE", {63'd0, ValidE}, 64'd0);
        chk("flush_CtrlE", {56'd0, CtrlE}, 64'd0);
        chk("flush_DataE", {32'd0, DataE}, 64'd0);
        chk("flush_ReadyD", {63'd0, ReadyD}, 64'd1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);

        // asynchronous reset in FULL, checked before the next edge
        cycle(1'b1, 8'h3C, 32'hCAFE_F00D, 1'b0, 1'b0);
        chk("full_ValidE", {63'd0, ValidE}, 64'd1);
        #2 RST = 1'b0;
        #1;
        chk("arst_ValidE", {63'd0, ValidE}, 64'd0);
        chk("arst_CtrlE", {56'd0, CtrlE}, 64'd0);
        chk("arst_DataE", {32'd0, DataE}, 64'd0);
        chk("arst_ReadyD", {63'd0, ReadyD}, 64'd0);
        model_reset();
        ValidD = 1'b0; ReadyE = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        cycle(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 8'h5A, 32'h0BAD_CAFE, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);

`ifdef STAGE_BUBBLE_CNT_EN
        // bubble counter saturation and CLR immunity
        RST = 1'b0;
        model_reset();
        @(negedge CLK);
        RST = 1'b1;
        cycle(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
        chk("bub_sat", {60'd0, BubbleCnt}, 64'd15);
        cycle(1'b0, 8'h00, 32'h0, 1'b1, 1'b1);
        chk("bub_clr", {60'd0, BubbleCnt}, 64'd15);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
